// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_mem_pkg
// Shared state, size and IO-decode constants for the byte-wide memory controller.
// Rev     : 1.0
// ============================================================================
package riscv_mem_pkg;

    localparam int LINE_BYTES_DEF = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_IC_READ  = 2'd1;
    localparam state_t ST_LS_READ  = 2'd2;
    localparam state_t ST_LS_WRITE = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Address bits [17:16] select the IO region.
    localparam logic [1:0] IO_SEL = 2'b11;

    function automatic logic is_io(input logic [1:0] sel);
        return sel == IO_SEL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl
// Arbitrates icache line fills and load/store accesses onto a byte-wide RAM/IO bus.
// Rev    : 1.0
// ============================================================================
module mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    clear,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_done,
    output logic [LINE_BYTES*8-1:0] ic_line,
    input  logic                    ls_req,
    input  logic                    ls_wr,
    input  logic [31:0]             ls_addr,
    input  logic [1:0]              ls_size,
    input  logic [31:0]             ls_wdata,
    output logic                    ls_done,
    output logic [31:0]             ls_rdata
);

    localparam int OFF = $clog2(LINE_BYTES);
    localparam int CW  = OFF + 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           nbytes;
    logic [31:0]             base;
    logic [31:0]             wdata;
    logic                    in_flight;
    logic                    wr_q;
    logic [LINE_BYTES*8-1:0] asm_data;

    logic [31:0]   cur_addr;
    logic [31:0]   line_base;
    logic [OFF-1:0] cap_idx;
    logic          io_stall;
    logic          ls_io_stall;
    logic [CW-1:0] ls_nbytes;

    always_comb begin
        cur_addr    = base + 32'(cnt);
        line_base   = ic_addr & ~LINE_MASK;
        cap_idx     = OFF'(cnt - CW'(1));
        io_stall    = is_io(cur_addr[17:16]) && io_buffer_full;
        ls_io_stall = is_io(ls_addr[17:16]) && io_buffer_full;
        case (ls_size)
            SIZE_B:  ls_nbytes = CW'(1);
            SIZE_H:  ls_nbytes = CW'(2);
            SIZE_W:  ls_nbytes = CW'(4);
            default: ls_nbytes = CW'(4);
        endcase
    end

    // A paused write is re-presented when rdy_in returns because wr_q is held.
    assign mem_wr = wr_q & rdy_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            nbytes    <= '0;
            base      <= '0;
            wdata     <= '0;
            in_flight <= 1'b0;
            wr_q      <= 1'b0;
            asm_data  <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            ic_done   <= 1'b0;
            ic_line   <= '0;
            ls_done   <= 1'b0;
            ls_rdata  <= '0;
        end else if (rdy_in) begin
            ic_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_a    <= '0;
                    mem_dout <= '0;
                    wr_q     <= 1'b0;
                    if (ls_req) begin
                        base     <= ls_addr;
                        wdata    <= ls_wdata;
                        nbytes   <= ls_nbytes;
                        asm_data <= '0;
                        if (ls_wr) begin
                            state <= ST_LS_WRITE;
                            if (ls_io_stall) begin
                                cnt       <= '0;
                                in_flight <= 1'b0;
                            end else begin
                                wr_q      <= 1'b1;
                                mem_a     <= ls_addr;
                                mem_dout  <= ls_wdata[7:0];
                                cnt       <= CW'(1);
                                in_flight <= 1'b1;
                            end
                        end else begin
                            state     <= ST_LS_READ;
                            mem_a     <= ls_addr;
                            cnt       <= CW'(1);
                            in_flight <= 1'b1;
                        end
                    end else if (ic_req && !clear) begin
                        state     <= ST_IC_READ;
                        base      <= line_base;
                        nbytes    <= CW'(LINE_BYTES);
                        asm_data  <= '0;
                        mem_a     <= line_base;
                        cnt       <= CW'(1);
                        in_flight <= 1'b1;
                    end
                end
                default: begin
                    if (state == ST_IC_READ && clear) begin
                        // Flush wins even over a completing line fill.
                        state     <= ST_IDLE;
                        mem_a     <= '0;
                        mem_dout  <= '0;
                        wr_q      <= 1'b0;
                        in_flight <= 1'b0;
                    end else begin
                        if (in_flight && state != ST_LS_WRITE)
                            asm_data[{cap_idx, 3'b000} +: 8] <= mem_din;
                        if (cnt < nbytes) begin
                            if (state == ST_LS_WRITE && io_stall) begin
                                wr_q      <= 1'b0;
                                mem_a     <= '0;
                                mem_dout  <= '0;
                                in_flight <= 1'b0;
                            end else begin
                                wr_q      <= (state == ST_LS_WRITE);
                                mem_a     <= cur_addr;
                                mem_dout  <= (state == ST_LS_WRITE) ?
                                             wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
                                cnt       <= cnt + CW'(1);
                                in_flight <= 1'b1;
                            end
                        end else if (in_flight) begin
                            wr_q      <= 1'b0;
                            mem_a     <= '0;
                            mem_dout  <= '0;
                            in_flight <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            if (state == ST_IC_READ) begin
                                ic_done <= 1'b1;
                                ic_line <= asm_data;
                            end else begin
                                ls_done <= 1'b1;
                                if (state == ST_LS_READ)
                                    ls_rdata <= asm_data[31:0];
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
